aes_inv_round_ctrl: RTL

Iterative AES inverse-cipher sequencer that runs one full decryption round per clock. It drives a single combinational round datapath built from the team's InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns blocks, all instantiated internally. Round keys come from an external key store addressed by round index. The block sits between the SPI-facing block buffer (upstream) and the plaintext output buffer (downstream), with valid/ready handshakes on both sides.

---
 rtl/aes_inv_round_ctrl_if.sv | 13 +
 rtl/aes_inv_round_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/aes_inv_round_ctrl_if.sv
// aes_inv_round_ctrl_if: ciphertext/plaintext handshakes and key-store port of the inverse-round sequencer
interface aes_inv_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    modport master (output in_valid, in_data, rk_data, out_ready, input in_ready, rk_idx, out_valid, out_data);
    modport slave  (input in_valid, in_data, rk_data, out_ready, output in_ready, rk_idx, out_valid, out_data);
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl: iterative AES inverse cipher, one full decryption round per clock
module aes_inv_round_ctrl #(
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    aes_inv_round_ctrl_if.slave  bus,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} state_t;
    localparam logic [3:0]  NR_IDX = 4'(NR);
    localparam logic [31:0] IMC    = 32'h0e0b0d09;
    state_t       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] core;
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] b;
        r = 8'h01;
        b = x;
        for (int i = 1; i < 8; i++) begin
            b = gf_mul(b, b);
            r = gf_mul(r, b);
        end
        return r;
    endfunction
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction
    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_sbox(s[8*k +: 8]);
        return r;
    endfunction
    // byte k = 4*col+row sits at bits [127-8k -: 8]; row r rotates right by r columns
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[8*(15-(4*c+w)) +: 8] = s[8*(15-(4*((c-w+4)%4)+w)) +: 8];
        return r;
    endfunction
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(IMC[8*(3-((j-w+4)%4)) +: 8], s[8*(15-(4*c+j)) +: 8]);
                r[8*(15-(4*c+w)) +: 8] = acc;
            end
        return r;
    endfunction
    assign core = inv_sub_bytes(inv_shift_rows(st_q));
    // next state, round datapath and round counter; clear overrides every transition
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rnd_d   = rnd_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    st_d    = bus.in_data ^ bus.rk_data;
                    rnd_d   = NR_IDX - 4'd1;
                    state_d = ROUND;
                end
                ROUND: begin
                    st_d    = inv_mix_columns(core ^ bus.rk_data);
                    rnd_d   = rnd_q - 4'd1;
                    state_d = (rnd_q == 4'd1) ? LAST : ROUND;
                end
                LAST: begin
                    st_d    = core ^ bus.rk_data;
                    state_d = DONE;
                end
                DONE: if (bus.out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
    // state, working block and round counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            st_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_data  = st_q;
    assign busy          = state_q != IDLE;
    assign bus.rk_idx    = (state_q == IDLE) ? NR_IDX : (state_q == ROUND) ? rnd_q : 4'd0;
endmodule
